// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster timing generator and pixel output stage.
// Counters produce the scan position. Compressed coordinates go to the renderers.
// Sync and blanking flags are delayed to line up with the renderer's intensity
// result, and the tinted RGB, sync and data enable leave through one output register.
module vga_scan_driver #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SHIFT    = 3,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] compr_hrw,
  output logic [6:0] compr_vrw,
  input  logic [3:0] colorv,
  input  logic [2:0] tint,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [31:0] H_LAST     = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST     = 32'(V_TOTAL - 1);
  localparam logic [31:0] H_ACT_END  = 32'(H_ACTIVE);
  localparam logic [31:0] V_ACT_END  = 32'(V_ACTIVE);
  localparam logic [31:0] H_SYNC_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] H_SYNC_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] V_SYNC_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] V_SYNC_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [31:0]   w_hcnt32;
  logic [31:0]   w_vcnt32;
  logic          w_hwrap;
  logic          w_vwrap;

  logic          w_act;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_act_d;
  logic          w_hs_d;
  logic          w_vs_d;
  logic          w_vblank_start;

  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [3:0]    r_red;
  logic [3:0]    r_green;
  logic [3:0]    r_blue;
  logic          r_frame_tick;
  logic [7:0]    r_frame_cnt;

  // Counter values widened to 32 bits so that every boundary compare is
  // exact, even when a boundary equals H_TOTAL/V_TOTAL.
  assign w_hcnt32 = 32'(r_hcnt);
  assign w_vcnt32 = 32'(r_vcnt);
  assign w_hwrap  = (w_hcnt32 == H_LAST);
  assign w_vwrap  = (w_vcnt32 == V_LAST);

  // Scan position: hcnt wraps each line, and vcnt steps on each hcnt wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_hwrap) begin
      r_hcnt <= '0;
      r_vcnt <= w_vwrap ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  // Renderer coordinates come straight from the counters. They are left unclamped in blanking.
  assign compr_hrw = 7'(r_hcnt >> SHIFT);
  assign compr_vrw = 7'(r_vcnt >> SHIFT);

  // Stage-0 flags decoded from the current scan position.
  assign w_act  = (w_hcnt32 < H_ACT_END) && (w_vcnt32 < V_ACT_END);
  assign w_hs_n = !((w_hcnt32 >= H_SYNC_BEG) && (w_hcnt32 < H_SYNC_END));
  assign w_vs_n = !((w_vcnt32 >= V_SYNC_BEG) && (w_vcnt32 < V_SYNC_END));

  // Flags are delayed by PIPE_LAT clocks to meet colorv. A latency of zero is a
  // direct path. Otherwise a shift register is used whose oldest bit is the MSB.
  // The input is concatenated below the register so that PIPE_LAT=1 needs no special case.
  if (PIPE_LAT == 0) begin : g_nopipe
    assign w_act_d = w_act;
    assign w_hs_d  = w_hs_n;
    assign w_vs_d  = w_vs_n;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] r_act_sr;
    logic [PIPE_LAT-1:0] r_hs_sr;
    logic [PIPE_LAT-1:0] r_vs_sr;
    logic [PIPE_LAT:0]   w_act_cat;
    logic [PIPE_LAT:0]   w_hs_cat;
    logic [PIPE_LAT:0]   w_vs_cat;

    assign w_act_cat = {r_act_sr, w_act};
    assign w_hs_cat  = {r_hs_sr,  w_hs_n};
    assign w_vs_cat  = {r_vs_sr,  w_vs_n};

    // Alignment shift register. It clears to the inactive, sync-deasserted state.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_act_sr <= '0;
        r_hs_sr  <= '1;
        r_vs_sr  <= '1;
      end else begin
        r_act_sr <= w_act_cat[PIPE_LAT-1:0];
        r_hs_sr  <= w_hs_cat[PIPE_LAT-1:0];
        r_vs_sr  <= w_vs_cat[PIPE_LAT-1:0];
      end
    end

    assign w_act_d = r_act_sr[PIPE_LAT-1];
    assign w_hs_d  = r_hs_sr[PIPE_LAT-1];
    assign w_vs_d  = r_vs_sr[PIPE_LAT-1];
  end

  // Output register: tinted intensity inside the visible area, otherwise zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else begin
      r_hsync <= w_hs_d;
      r_vsync <= w_vs_d;
      r_de    <= w_act_d;
      r_red   <= (w_act_d && tint[2]) ? colorv : '0;
      r_green <= (w_act_d && tint[1]) ? colorv : '0;
      r_blue  <= (w_act_d && tint[0]) ? colorv : '0;
    end
  end

  // The first blanking line begins at (0, V_ACTIVE). This point can never
  // coincide with the frame wrap, because V_ACTIVE is below V_TOTAL.
  assign w_vblank_start = (r_hcnt == '0) && (w_vcnt32 == V_ACT_END);

  // Frame pacing: one-clock tick and a wrapping frame count. Neither passes
  // through the alignment pipe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_tick <= w_vblank_start;
      if (w_vblank_start) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign de         = r_de;
  assign red        = r_red;
  assign green      = r_green;
  assign blue       = r_blue;
  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;

endmodule
